mode_controller: RTL and testbench
==================================

Name: mode_controller

Overview:
- Top-level sequencer for the four time units: clock, stopwatch, countdown timer and alarm.
- Divides the board clock into a 1 ms tick shared by all units.
- Selects which unit owns the display and the debounced buttons.
- Runs an alert sequence when the timer or alarm asserts done, blinking the display and pulsing a clear back to the source unit.

Parameters:
CLK_DIV, 100000, board clock cycles per 1 ms tick (legal range 2..2^20)
ALERT_MS, 10000, alert duration in ticks before auto-dismiss (1..65535)
BLINK_MS, 250, ticks per display blink half-period during alert (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bU  in  1  mode-cycle button, single-cycle debounced pulse
bC  in  1  centre button pulse
bL  in  1  left button pulse
bD  in  1  down button pulse
bR  in  1  right button pulse
unit_time  in  144  four 36-bit BCD buses (hh:mm:ss.mmm), unit k at [36k+35:36k]; 0=clock, 1=stopwatch, 2=timer, 3=alarm
unit_edit  in  4  unit k is in edit mode
unit_done  in  4  unit k done level; only bits 2 and 3 are used
tick_o  out  1  one-cycle pulse every CLK_DIV cycles
mode_o  out  2  currently selected unit
route_bC  out  4  one-hot routed centre pulse; route_bL, route_bD and route_bR are identical in form
route_bL  out  4  see route_bC
route_bD  out  4  see route_bC
route_bR  out  4  see route_bC
disp_o  out  36  BCD value to the display driver
alert_o  out  1  high while in ALERT
clear_o  out  4  one-cycle done-clear pulse to unit k

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: tick_o=0, mode_o=0, all route_*=0, disp_o=0, alert_o=0, clear_o=0.
  - Internal: prescaler=0, FSM=NORMAL, done_prev=0, pend_alarm=0, blink phase=1.
  - Reset asserted mid-alert aborts the alert with no clear pulse.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick_o is registered and high exactly in the cycle after the count equals CLK_DIV-1.
  - First tick comes CLK_DIV cycles after reset release.
- FSM states: NORMAL, ALERT.
- NORMAL:
  - bU advances mode_o as (mode_o+1) mod 4 (3 wraps to 0). bU is ignored while unit_edit[mode_o]=1.
  - bC/bL/bD/bR are routed registered, 1-cycle latency: route_x <= bx ? (1<<mode_o) : 0.
  - bU is never routed.
  - Simultaneous bU and bx: bx is routed to the old mode, then the mode advances.
  - disp_o <= unit_time slice[mode_o], 1-cycle latency.
- Alert trigger:
  - A rising edge is detected on unit_done[2] or unit_done[3], against a registered previous value.
  - In NORMAL, on a rising edge of source s (timer wins if both rise in the same cycle, and pend_alarm is set for the other): next state is ALERT, src<=s, mode_o<=s, alert_o<=1, alert counter<=ALERT_MS, blink counter<=BLINK_MS, phase=1.
  - A trigger in the same cycle as bU takes priority; bU is dropped and no buttons are routed that cycle.
  - A rising edge while already in ALERT:
    - sets pend_alarm if it is an alarm edge with src=timer;
    - sets pend_timer if it is a timer edge with src=alarm;
    - is ignored if it is the same source as src.
- ALERT:
  - All route_* stay 0.
  - On each tick the alert counter decrements. The blink counter also decrements; at 1 it reloads BLINK_MS and toggles phase.
  - disp_o = phase ? unit_time slice[src] : 36'h0.
  - Exit when any of bU/bC/bL/bD/bR is seen, or when the alert counter reaches 0 on a tick:
    - clear_o[src]=1 for exactly one cycle (the cycle after exit is decided);
    - alert_o<=0, FSM<=NORMAL; mode_o stays at src.
  - Button press and expiry in the same cycle: a single exit with a single clear.
- Pending alert: in the first NORMAL cycle after exit, any pending flag re-enters ALERT for that source and clears the flag. Timer is served before alarm.
- unit_edit has no effect in ALERT.

Test Plan:
- Reset then run with CLK_DIV=4:
  - tick_o pulses at cycles 4, 8 and 12 after release;
  - mode_o=0 and disp_o=unit_time[35:0] one cycle after reset release.
- bU pressed 5 times with unit_edit=0:
  - mode_o sequence is 1, 2, 3, 0, 1;
  - a bC pulse in mode 1 gives route_bC=4'b0010 one cycle later and other bits 0.
- unit_edit[2]=1 with mode_o=2, then bU:
  - mode_o stays 2;
  - after unit_edit[2]=0, a bU press gives mode_o=3.
- mode_o=0, unit_done[2] rises, ALERT_MS=5, BLINK_MS=2, no buttons:
  - mode_o=2, alert_o=1;
  - disp_o alternates timer value / 0 every 2 ticks;
  - after 5 ticks, clear_o=4'b0100 for one cycle and alert_o=0.
- unit_done[2] and unit_done[3] rise in the same cycle, then bR during the alert:
  - clear_o=4'b0100, with route_bR staying 0;
  - next cycle, ALERT for src=3 with mode_o=3;
  - bC then gives clear_o=4'b1000.
- Assert rst_n=0 mid-ALERT:
  - alert_o=0, clear_o=0 and mode_o=0 immediately (asynchronously);
  - a still-high unit_done[2] after release triggers no alert until it falls and rises again.

Source files
------------

// File: rtl/mode_controller_if.sv
// Purpose : bundles the debounced buttons, unit status buses and controller outputs.
// Latency : n/a (wires only).
// Backpressure: none; buttons are single-cycle pulses, outputs are registered levels/pulses.
//
// Ports (master = board/units side, slave = mode_controller):
//   bU,bC,bL,bD,bR  debounced single-cycle button pulses
//   unit_time       four 36-bit BCD time buses, unit k at [36k+35:36k]
//   unit_edit       unit k is in edit mode
//   unit_done       unit k done level (timer = 2, alarm = 3)
//   tick_o          1 ms tick pulse
//   mode_o          selected unit
//   route_b*        one-hot routed button pulses
//   disp_o          BCD value for the display driver
//   alert_o         alert sequence active
//   clear_o         one-cycle done-clear pulse to unit k
interface mode_controller_if;
  logic         bU;
  logic         bC;
  logic         bL;
  logic         bD;
  logic         bR;
  logic [143:0] unit_time;
  logic [3:0]   unit_edit;
  logic [3:0]   unit_done;

  logic         tick_o;
  logic [1:0]   mode_o;
  logic [3:0]   route_bC;
  logic [3:0]   route_bL;
  logic [3:0]   route_bD;
  logic [3:0]   route_bR;
  logic [35:0]  disp_o;
  logic         alert_o;
  logic [3:0]   clear_o;

  modport master (
    output bU, bC, bL, bD, bR, unit_time, unit_edit, unit_done,
    input  tick_o, mode_o, route_bC, route_bL, route_bD, route_bR,
           disp_o, alert_o, clear_o
  );

  modport slave (
    input  bU, bC, bL, bD, bR, unit_time, unit_edit, unit_done,
    output tick_o, mode_o, route_bC, route_bL, route_bD, route_bR,
           disp_o, alert_o, clear_o
  );
endinterface

// File: rtl/mode_controller.sv
// Purpose : top-level sequencer for clock/stopwatch/timer/alarm: 1 ms prescaler, unit select, alert sequence.
// Latency : all outputs registered; buttons route and display follows with 1 cycle latency.
// Backpressure: none; button pulses are consumed or dropped in the cycle they arrive.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    mode_controller_if.slave (buttons, unit status in; tick, mode, routes, display, alert, clear out)
module mode_controller #(
  parameter int CLK_DIV  = 100000,
  parameter int ALERT_MS = 10000,
  parameter int BLINK_MS = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  mode_controller_if.slave bus
);

  localparam int            CW         = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [15:0]   ALERT_INIT = 16'(ALERT_MS);
  localparam logic [15:0]   BLINK_INIT = 16'(BLINK_MS);
  localparam logic [1:0]    SRC_TIMER  = 2'd2;
  localparam logic [1:0]    SRC_ALARM  = 2'd3;

  typedef enum logic {
    NORMAL,
    ALERT
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    src_q, src_d;
  logic [15:0]   alert_cnt_q, alert_cnt_d;
  logic [15:0]   blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [1:0]    done_prev_q, done_prev_d;   // [0]=timer, [1]=alarm
  logic          armed_q, armed_d;
  logic          pend_timer_q, pend_timer_d;
  logic          pend_alarm_q, pend_alarm_d;
  logic [3:0]    route_c_q, route_c_d;
  logic [3:0]    route_l_q, route_l_d;
  logic [3:0]    route_d_q, route_d_d;
  logic [3:0]    route_r_q, route_r_d;
  logic [35:0]   disp_q, disp_d;
  logic [3:0]    clear_q, clear_d;

  // Only the timer and alarm done levels can raise an alert.
  logic unused_done;
  assign unused_done = ^bus.unit_done[1:0];

  logic [1:0] done_rise;
  logic       want_timer;
  logic       want_alarm;
  logic       any_btn;
  logic       alert_exit;
  logic [3:0] mode_hot;

  function automatic logic [35:0] unit_slice(input logic [143:0] t, input logic [1:0] k);
    logic [35:0] r;
    case (k)
      2'd0:    r = t[35:0];
      2'd1:    r = t[71:36];
      2'd2:    r = t[107:72];
      default: r = t[143:108];
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // 1 ms prescaler; tick is registered so it lands one cycle after the wrap count
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_d = (div_q == DIV_LAST);
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Done edge detection. The first cycle after reset only samples the levels, so
  // a done that is still high when reset releases is not mistaken for a new edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    done_prev_d = bus.unit_done[3:2];
    armed_d     = 1'b1;
    done_rise   = armed_q ? (bus.unit_done[3:2] & ~done_prev_q) : 2'b00;
  end

  assign any_btn  = bus.bU | bus.bC | bus.bL | bus.bD | bus.bR;
  assign mode_hot = 4'b0001 << mode_q;

  // Pending flags only exist in the first NORMAL cycle after an exit, so folding
  // them in with fresh edges serves them there, timer first.
  assign want_timer = done_rise[0] | pend_timer_q;
  assign want_alarm = done_rise[1] | pend_alarm_q;

  // Expiry is judged on the tick that would take the counter from 1 to 0.
  assign alert_exit = any_btn | (tick_q & (alert_cnt_q == 16'd1));

  // ---------------------------------------------------------------------------
  // Mode / alert FSM, next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    src_d        = src_q;
    alert_cnt_d  = alert_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    pend_timer_d = pend_timer_q;
    pend_alarm_d = pend_alarm_q;
    route_c_d    = '0;
    route_l_d    = '0;
    route_d_d    = '0;
    route_r_d    = '0;
    clear_d      = '0;
    disp_d       = unit_slice(bus.unit_time, mode_q);

    case (state_q)
      NORMAL: begin
        if (want_timer || want_alarm) begin
          // Alert entry swallows any buttons arriving in the same cycle.
          state_d      = ALERT;
          src_d        = want_timer ? SRC_TIMER : SRC_ALARM;
          mode_d       = want_timer ? SRC_TIMER : SRC_ALARM;
          alert_cnt_d  = ALERT_INIT;
          blink_cnt_d  = BLINK_INIT;
          phase_d      = 1'b1;
          pend_timer_d = 1'b0;
          pend_alarm_d = want_timer & want_alarm;
        end else begin
          // Buttons go to the unit selected before any bU advance this cycle.
          route_c_d = bus.bC ? mode_hot : 4'b0000;
          route_l_d = bus.bL ? mode_hot : 4'b0000;
          route_d_d = bus.bD ? mode_hot : 4'b0000;
          route_r_d = bus.bR ? mode_hot : 4'b0000;
          if (bus.bU && !bus.unit_edit[mode_q]) begin
            mode_d = mode_q + 2'd1;
          end
        end
      end

      ALERT: begin
        disp_d = phase_q ? unit_slice(bus.unit_time, src_q) : 36'h0;

        // The other source queues behind the current alert; a repeat of the
        // current source is already being served.
        if (done_rise[1] && (src_q == SRC_TIMER)) begin
          pend_alarm_d = 1'b1;
        end
        if (done_rise[0] && (src_q == SRC_ALARM)) begin
          pend_timer_d = 1'b1;
        end

        if (tick_q) begin
          alert_cnt_d = alert_cnt_q - 16'd1;
          if (blink_cnt_q == 16'd1) begin
            blink_cnt_d = BLINK_INIT;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q - 16'd1;
          end
        end

        if (alert_exit) begin
          state_d = NORMAL;
          clear_d = 4'b0001 << src_q;
        end
      end

      default: begin
        state_d = NORMAL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      tick_q       <= 1'b0;
      state_q      <= NORMAL;
      mode_q       <= 2'd0;
      src_q        <= 2'd0;
      alert_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      done_prev_q  <= 2'b00;
      armed_q      <= 1'b0;
      pend_timer_q <= 1'b0;
      pend_alarm_q <= 1'b0;
      route_c_q    <= '0;
      route_l_q    <= '0;
      route_d_q    <= '0;
      route_r_q    <= '0;
      disp_q       <= '0;
      clear_q      <= '0;
    end else begin
      div_q        <= div_d;
      tick_q       <= tick_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      src_q        <= src_d;
      alert_cnt_q  <= alert_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      done_prev_q  <= done_prev_d;
      armed_q      <= armed_d;
      pend_timer_q <= pend_timer_d;
      pend_alarm_q <= pend_alarm_d;
      route_c_q    <= route_c_d;
      route_l_q    <= route_l_d;
      route_d_q    <= route_d_d;
      route_r_q    <= route_r_d;
      disp_q       <= disp_d;
      clear_q      <= clear_d;
    end
  end

  assign bus.tick_o   = tick_q;
  assign bus.mode_o   = mode_q;
  assign bus.route_bC = route_c_q;
  assign bus.route_bL = route_l_q;
  assign bus.route_bD = route_d_q;
  assign bus.route_bR = route_r_q;
  assign bus.disp_o   = disp_q;
  assign bus.alert_o  = (state_q == ALERT);
  assign bus.clear_o  = clear_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_clear_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(clear_q));
  a_route_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(route_c_q) && $onehot0(route_l_q) && $onehot0(route_d_q) && $onehot0(route_r_q));
  a_route_quiet_in_alert: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ALERT) |-> ((route_c_q | route_l_q | route_d_q | route_r_q) == 4'b0000));
  a_clear_after_alert: assert property (@(posedge clk) disable iff (!rst_n)
    (clear_q != 4'b0000) |-> (state_q == NORMAL));

endmodule

// File: tb/tb_mode_controller.sv
module tb_mode_controller;

  localparam int CLK_DIV  = 4;
  localparam int ALERT_MS = 5;
  localparam int BLINK_MS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mode_controller_if ifc ();

  mode_controller #(
    .CLK_DIV (CLK_DIV),
    .ALERT_MS(ALERT_MS),
    .BLINK_MS(BLINK_MS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: time-in-alert counted in ticks, blink phase derived
  // arithmetically from that count, pending alerts as two flags.
  // ---------------------------------------------------------------------------
  int       m_edges;
  int       m_mode;
  int       m_src;
  int       m_ticks;
  bit       m_in_alert;
  bit       m_armed;
  bit       m_pend_t;
  bit       m_pend_a;
  bit [1:0] m_prev;

  logic        e_tick;
  logic [1:0]  e_mode;
  logic [3:0]  e_rc, e_rl, e_rd, e_rr, e_clear;
  logic [35:0] e_disp;
  logic        e_alert;

  function automatic logic [35:0] slice_of(input int k);
    return ifc.unit_time[36*k +: 36];
  endfunction

  task automatic model_reset();
    m_edges = 0; m_mode = 0; m_src = 0; m_ticks = 0;
    m_in_alert = 0; m_armed = 0; m_pend_t = 0; m_pend_a = 0; m_prev = 2'b00;
    e_tick = 0; e_mode = 0; e_rc = 0; e_rl = 0; e_rd = 0; e_rr = 0;
    e_clear = 0; e_disp = 0; e_alert = 0;
  endtask

  task automatic model_step();
    bit cur_tick, rise_t, rise_a, wt, wa, btn;
    logic [3:0] hot;
    cur_tick = e_tick;
    rise_t = m_armed && ifc.unit_done[2] && !m_prev[0];
    rise_a = m_armed && ifc.unit_done[3] && !m_prev[1];
    btn = ifc.bU | ifc.bC | ifc.bL | ifc.bD | ifc.bR;
    hot = 4'b0001 << m_mode;
    e_rc = 0; e_rl = 0; e_rd = 0; e_rr = 0; e_clear = 0;
    if (!m_in_alert) begin
      e_disp = slice_of(m_mode);
      wt = rise_t || m_pend_t;
      wa = rise_a || m_pend_a;
      if (wt || wa) begin
        m_src = wt ? 2 : 3;
        m_mode = m_src;
        m_in_alert = 1;
        m_ticks = 0;
        m_pend_t = 0;
        m_pend_a = wt && wa;
      end else begin
        if (ifc.bC) e_rc = hot;
        if (ifc.bL) e_rl = hot;
        if (ifc.bD) e_rd = hot;
        if (ifc.bR) e_rr = hot;
        if (ifc.bU && !ifc.unit_edit[m_mode]) m_mode = (m_mode + 1) % 4;
      end
    end else begin
      e_disp = (((m_ticks / BLINK_MS) % 2) == 0) ? slice_of(m_src) : 36'h0;
      if (rise_a && m_src == 2) m_pend_a = 1;
      if (rise_t && m_src == 3) m_pend_t = 1;
      if (cur_tick) m_ticks++;
      if (btn || (cur_tick && m_ticks == ALERT_MS)) begin
        m_in_alert = 0;
        e_clear = 4'b0001 << m_src;
      end
    end
    m_edges++;
    e_tick = ((m_edges % CLK_DIV) == 0);
    m_prev = {ifc.unit_done[3], ifc.unit_done[2]};
    m_armed = 1;
    e_mode = 2'(m_mode);
    e_alert = m_in_alert;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (checking) begin
      chk("tick_o",   64'(ifc.tick_o),   64'(e_tick));
      chk("mode_o",   64'(ifc.mode_o),   64'(e_mode));
      chk("route_bC", 64'(ifc.route_bC), 64'(e_rc));
      chk("route_bL", 64'(ifc.route_bL), 64'(e_rl));
      chk("route_bD", 64'(ifc.route_bD), 64'(e_rd));
      chk("route_bR", 64'(ifc.route_bR), 64'(e_rr));
      chk("disp_o",   64'(ifc.disp_o),   64'(e_disp));
      chk("alert_o",  64'(ifc.alert_o),  64'(e_alert));
      chk("clear_o",  64'(ifc.clear_o),  64'(e_clear));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_buttons();
    ifc.bU = 0; ifc.bC = 0; ifc.bL = 0; ifc.bD = 0; ifc.bR = 0;
  endtask

  task automatic press(input int which);
    case (which)
      0: ifc.bU = 1;
      1: ifc.bC = 1;
      2: ifc.bL = 1;
      3: ifc.bD = 1;
      default: ifc.bR = 1;
    endcase
    @(negedge clk);
    release_buttons();
  endtask

  task automatic new_times();
    logic [143:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    // keep every slice non-zero so a blanked display is unambiguous
    t[0] = 1'b1; t[36] = 1'b1; t[72] = 1'b1; t[108] = 1'b1;
    ifc.unit_time = t;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual running, required finished");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios followed by a randomized run
  // ---------------------------------------------------------------------------
  initial begin
    int exp_modes [5] = '{1, 2, 3, 0, 1};
    int zeros;
    int n;

    release_buttons();
    ifc.unit_edit = 4'b0000;
    ifc.unit_done = 4'b0000;
    new_times();

    // reset
    #1 rst_n = 1'b0;
    checking = 1'b1;
    #1;
    chk("reset_tick",  64'(ifc.tick_o), 64'd0);
    chk("reset_mode",  64'(ifc.mode_o), 64'd0);
    chk("reset_disp",  64'(ifc.disp_o), 64'd0);
    chk("reset_alert", 64'(ifc.alert_o), 64'd0);
    chk("reset_clear", 64'(ifc.clear_o), 64'd0);
    chk("reset_route", 64'({ifc.route_bC, ifc.route_bL, ifc.route_bD, ifc.route_bR}), 64'd0);
    cyc(3);
    rst_n = 1'b1;

    // prescaler: ticks at cycles 4, 8, 12 after release
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("tick_c%0d", k), 64'(ifc.tick_o), 64'((k % 4) == 0));
      if (k == 1) begin
        chk("mode_after_rst", 64'(ifc.mode_o), 64'd0);
        chk("disp_after_rst", 64'(ifc.disp_o), 64'(ifc.unit_time[35:0]));
      end
    end

    // mode cycling
    for (int i = 0; i < 5; i++) begin
      press(0);
      chk($sformatf("mode_seq%0d", i), 64'(ifc.mode_o), 64'(exp_modes[i]));
    end
    press(1);
    chk("route_bC_mode1", 64'(ifc.route_bC), 64'h2);
    chk("route_bL_idle",  64'(ifc.route_bL), 64'h0);
    cyc(1);
    chk("route_bC_pulse", 64'(ifc.route_bC), 64'h0);

    // edit lock
    press(0);
    chk("mode_to_2", 64'(ifc.mode_o), 64'd2);
    ifc.unit_edit = 4'b0100;
    press(0);
    chk("mode_edit_hold", 64'(ifc.mode_o), 64'd2);
    ifc.unit_edit = 4'b0000;
    press(0);
    chk("mode_after_edit", 64'(ifc.mode_o), 64'd3);
    press(0);
    chk("mode_wrap", 64'(ifc.mode_o), 64'd0);

    // timer alert runs to expiry
    ifc.unit_done = 4'b0100;
    cyc(1);
    chk("alert_t_mode",  64'(ifc.mode_o), 64'd2);
    chk("alert_t_alert", 64'(ifc.alert_o), 64'd1);
    zeros = 0;
    n = 0;
    while (ifc.clear_o == 4'b0000 && n < 100) begin
      if (ifc.alert_o && ifc.disp_o == 36'h0) zeros++;
      @(negedge clk);
      n++;
    end
    chk("alert_t_clear", 64'(ifc.clear_o), 64'h4);
    chk("alert_t_off",   64'(ifc.alert_o), 64'd0);
    chk("blink_zero_cycles", 64'(zeros), 64'(BLINK_MS * CLK_DIV));
    cyc(1);
    chk("alert_t_clear_1cyc", 64'(ifc.clear_o), 64'h0);
    ifc.unit_done = 4'b0000;
    cyc(2);

    // simultaneous timer+alarm, bR dismisses timer, alarm follows
    ifc.unit_done = 4'b1100;
    cyc(1);
    chk("dual_mode",  64'(ifc.mode_o), 64'd2);
    chk("dual_alert", 64'(ifc.alert_o), 64'd1);
    cyc(3);
    press(4);
    chk("dual_clear_t", 64'(ifc.clear_o), 64'h4);
    chk("dual_route_r", 64'(ifc.route_bR), 64'h0);
    cyc(1);
    chk("dual_alarm_alert", 64'(ifc.alert_o), 64'd1);
    chk("dual_alarm_mode",  64'(ifc.mode_o), 64'd3);
    cyc(2);
    press(1);
    chk("dual_clear_a", 64'(ifc.clear_o), 64'h8);
    chk("dual_route_c", 64'(ifc.route_bC), 64'h0);
    ifc.unit_done = 4'b0000;
    cyc(2);

    // randomized run
    for (int c = 0; c < 3000; c++) begin
      ifc.bU = ($urandom_range(0, 39) == 0);
      ifc.bC = ($urandom_range(0, 39) == 0);
      ifc.bL = ($urandom_range(0, 39) == 0);
      ifc.bD = ($urandom_range(0, 39) == 0);
      ifc.bR = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) ifc.unit_edit = 4'($urandom);
      if ($urandom_range(0, 24) == 0) ifc.unit_done[2] = ~ifc.unit_done[2];
      if ($urandom_range(0, 24) == 0) ifc.unit_done[3] = ~ifc.unit_done[3];
      if ($urandom_range(0, 3) == 0) ifc.unit_done[1:0] = 2'($urandom);
      new_times();
      @(negedge clk);
    end
    release_buttons();
    ifc.unit_done = 4'b0000;
    ifc.unit_edit = 4'b0000;
    press(1);
    cyc(2);
    press(1);
    cyc(2);
    press(1);
    cyc(2);
    chk("quiet_after_random", 64'(ifc.alert_o), 64'd0);

    // reset in the middle of an alert
    ifc.unit_done = 4'b0100;
    cyc(3);
    chk("pre_rst_alert", 64'(ifc.alert_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_alert", 64'(ifc.alert_o), 64'd0);
    chk("async_clear", 64'(ifc.clear_o), 64'h0);
    chk("async_mode",  64'(ifc.mode_o), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    chk("held_done_no_alert", 64'(ifc.alert_o), 64'd0);
    chk("held_done_no_clear", 64'(ifc.clear_o), 64'h0);
    ifc.unit_done = 4'b0000;
    cyc(2);
    ifc.unit_done = 4'b0100;
    cyc(1);
    chk("rearm_alert", 64'(ifc.alert_o), 64'd1);
    chk("rearm_mode",  64'(ifc.mode_o), 64'd2);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
